// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared encodings for the multicycle RV32I control unit
//
// Purpose: FSM state encoding, RV32I opcode constants, instruction classes,
// ALU op codes and the mux-select / trap-cause encodings used by the control
// unit and its decoder. Also holds the ALU op derivation helper.
// Ports: none (package).

package control_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   // RV32I major opcodes
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [3:0] {
      CL_OP, CL_OP_IMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL,
      CL_JALR, CL_LUI, CL_AUIPC, CL_FENCE, CL_SYSTEM, CL_NONE
   } iclass_e;

   // ALU op codes: {funct7[5], funct3}
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1101;

   localparam logic SRC1_RS1 = 1'b0;
   localparam logic SRC1_PC  = 1'b1;

   typedef enum logic [1:0] {
      SRC2_IMM_I = 2'b00,
      SRC2_IMM_S = 2'b01,
      SRC2_RS2   = 2'b10,
      SRC2_IMM_U = 2'b11
   } alu_src2_e;

   typedef enum logic [1:0] {
      WB_IMM_U = 2'b00,
      WB_ALU   = 2'b01,
      WB_DMEM  = 2'b10,
      WB_PC4   = 2'b11
   } wb_src_e;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'b00,
      PC_TARGET = 2'b01,
      PC_ALU    = 2'b10,
      PC_TRAP   = 2'b11
   } pc_src_e;

   typedef enum logic [1:0] {
      CAUSE_ILLEGAL = 2'b00,
      CAUSE_ECALL   = 2'b01,
      CAUSE_IMEM_TO = 2'b10,
      CAUSE_DMEM_TO = 2'b11
   } trap_cause_e;

   // Shifts need funct7[5] to tell SRL from SRA; other OP-IMM forms carry
   // immediate bits in that position, so it is forced to 0 for them.
   function automatic logic [3:0] alu_op_f(iclass_e cls, logic [2:0] f3, logic f7_5);
      logic [3:0] op;
      op = ALU_ADD;
      case (cls)
         CL_OP:     op = {f7_5, f3};
         CL_OP_IMM: op = (f3 == 3'b001 || f3 == 3'b101) ? {f7_5, f3} : {1'b0, f3};
         default:   op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/main_decoder.sv
// rtl/main_decoder.sv - combinational RV32I opcode/funct decoder
//
// Purpose: classify the latched instruction and flag encodings that the core
// does not implement.
// Ports:
//   opcode_i, funct3_i, funct7_i : instruction register fields
//   iclass_o                     : instruction class
//   illegal_o                    : unsupported opcode or bad funct3/funct7

module main_decoder
   import control_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output iclass_e    iclass_o,
   output logic       illegal_o
);

   always_comb begin
      iclass_o  = CL_NONE;
      illegal_o = 1'b0;
      case (opcode_i)
         OPC_OP: begin
            iclass_o  = CL_OP;
            // only SUB and SRA use the alternate funct7
            illegal_o = !((funct7_i == 7'b0000000) ||
                          (funct7_i == 7'b0100000 &&
                           (funct3_i == 3'b000 || funct3_i == 3'b101)));
         end
         OPC_OP_IMM: begin
            iclass_o = CL_OP_IMM;
            if (funct3_i == 3'b001)
               illegal_o = (funct7_i != 7'b0000000);
            else if (funct3_i == 3'b101)
               illegal_o = !(funct7_i == 7'b0000000 || funct7_i == 7'b0100000);
         end
         OPC_LOAD: begin
            iclass_o  = CL_LOAD;
            illegal_o = (funct3_i == 3'b011) || (funct3_i == 3'b110) || (funct3_i == 3'b111);
         end
         OPC_STORE: begin
            iclass_o  = CL_STORE;
            illegal_o = funct3_i[2] || (funct3_i[1:0] == 2'b11);
         end
         OPC_BRANCH: begin
            iclass_o  = CL_BRANCH;
            illegal_o = (funct3_i[2:1] == 2'b01);
         end
         OPC_JALR: begin
            iclass_o  = CL_JALR;
            illegal_o = (funct3_i != 3'b000);
         end
         // plain FENCE only; FENCE.I is not part of this core
         OPC_MISC_MEM: begin
            iclass_o  = CL_FENCE;
            illegal_o = (funct3_i != 3'b000);
         end
         OPC_JAL:    iclass_o = CL_JAL;
         OPC_LUI:    iclass_o = CL_LUI;
         OPC_AUIPC:  iclass_o = CL_AUIPC;
         OPC_SYSTEM: iclass_o = CL_SYSTEM;
         default:    illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle RV32I control FSM with memory watchdog
//
// Purpose: sequences FETCH/DECODE/EXEC/MEM/WB/TRAP and drives datapath
// controls combinationally from the current state and instruction fields.
// Ports:
//   clk_i, rst_i                         : clock, synchronous active-high reset
//   opcode_i, funct3_i, funct7_i         : instruction register fields
//   branch_taken_i                       : branch comparator result
//   imem_req_o / imem_ready_i            : instruction fetch handshake
//   dmem_req_o / dmem_ready_i            : data access handshake
//   ir_load_o                            : instruction register load strobe
//   reg_write_enable_o, mem_write_enable_o
//   alu_src_1_o, alu_src_2_o, alu_op_o   : ALU operand selects and operation
//   reg_write_src_o, pc_write_o, pc_src_o: writeback / PC update controls
//   trap_o, trap_cause_o, state_o        : trap strobe, sticky cause, FSM state

module multicycle_control
   import control_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0,
   parameter int unsigned TIMEOUT_W      = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   input  logic       branch_taken_i,
   output logic       imem_req_o,
   input  logic       imem_ready_i,
   output logic       dmem_req_o,
   input  logic       dmem_ready_i,
   output logic       ir_load_o,
   output logic       reg_write_enable_o,
   output logic       mem_write_enable_o,
   output logic       alu_src_1_o,
   output logic [1:0] alu_src_2_o,
   output logic [3:0] alu_op_o,
   output logic [1:0] reg_write_src_o,
   output logic       pc_write_o,
   output logic [1:0] pc_src_o,
   output logic       trap_o,
   output logic [1:0] trap_cause_o,
   output logic [2:0] state_o
);

   localparam bit WD_ON = (TIMEOUT_CYCLES != 0);
   // The request is held for TIMEOUT_CYCLES cycles; the last of them is the
   // one where the counter shows TIMEOUT_CYCLES-1, so ready sampled in that
   // cycle still wins over the timeout.
   localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   state_e                 state_q, state_d;
   logic [TIMEOUT_W-1:0]   wd_q, wd_d;
   trap_cause_e            cause_q, cause_d;

   iclass_e                iclass;
   logic                   illegal;
   logic                   wd_expired;

   main_decoder u_main_decoder (
      .opcode_i  (opcode_i),
      .funct3_i  (funct3_i),
      .funct7_i  (funct7_i),
      .iclass_o  (iclass),
      .illegal_o (illegal)
   );

   assign wd_expired = WD_ON && (wd_q == WD_LAST);

   always_comb begin
      state_d            = state_q;
      wd_d               = wd_q;
      cause_d            = cause_q;
      imem_req_o         = 1'b0;
      dmem_req_o         = 1'b0;
      ir_load_o          = 1'b0;
      reg_write_enable_o = 1'b0;
      mem_write_enable_o = 1'b0;
      alu_src_1_o        = SRC1_RS1;
      alu_src_2_o        = SRC2_IMM_I;
      alu_op_o           = ALU_ADD;
      reg_write_src_o    = WB_IMM_U;
      pc_write_o         = 1'b0;
      pc_src_o           = PC_PLUS4;
      trap_o             = 1'b0;

      case (state_q)
         ST_FETCH: begin
            imem_req_o = 1'b1;
            if (imem_ready_i) begin
               ir_load_o = 1'b1;
               state_d   = ST_DECODE;
            end else if (wd_expired) begin
               cause_d = CAUSE_IMEM_TO;
               state_d = ST_TRAP;
            end else if (WD_ON) begin
               wd_d = wd_q + 1'b1;
            end
         end

         ST_DECODE: begin
            if (iclass == CL_SYSTEM) begin
               cause_d = CAUSE_ECALL;
               state_d = ST_TRAP;
            end else if (illegal) begin
               cause_d = CAUSE_ILLEGAL;
               state_d = ST_TRAP;
            end else begin
               state_d = ST_EXEC;
            end
         end

         ST_EXEC: begin
            alu_op_o = alu_op_f(iclass, funct3_i, funct7_i[5]);
            case (iclass)
               CL_OP, CL_BRANCH: alu_src_2_o = SRC2_RS2;
               CL_STORE:         alu_src_2_o = SRC2_IMM_S;
               CL_AUIPC: begin
                  alu_src_1_o = SRC1_PC;
                  alu_src_2_o = SRC2_IMM_U;
               end
               default:          alu_src_2_o = SRC2_IMM_I;
            endcase
            case (iclass)
               CL_LOAD, CL_STORE: state_d = ST_MEM;
               CL_BRANCH: begin
                  pc_write_o = 1'b1;
                  pc_src_o   = branch_taken_i ? PC_TARGET : PC_PLUS4;
                  state_d    = ST_FETCH;
               end
               CL_FENCE: begin
                  pc_write_o = 1'b1;
                  pc_src_o   = PC_PLUS4;
                  state_d    = ST_FETCH;
               end
               default: state_d = ST_WB;
            endcase
         end

         ST_MEM: begin
            dmem_req_o         = 1'b1;
            mem_write_enable_o = (iclass == CL_STORE);
            if (dmem_ready_i) begin
               if (iclass == CL_STORE) begin
                  pc_write_o = 1'b1;
                  pc_src_o   = PC_PLUS4;
                  state_d    = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end else if (wd_expired) begin
               cause_d = CAUSE_DMEM_TO;
               state_d = ST_TRAP;
            end else if (WD_ON) begin
               wd_d = wd_q + 1'b1;
            end
         end

         ST_WB: begin
            reg_write_enable_o = 1'b1;
            pc_write_o         = 1'b1;
            case (iclass)
               CL_JAL: begin
                  pc_src_o        = PC_TARGET;
                  reg_write_src_o = WB_PC4;
               end
               CL_JALR: begin
                  pc_src_o        = PC_ALU;
                  reg_write_src_o = WB_PC4;
               end
               CL_LUI:  reg_write_src_o = WB_IMM_U;
               CL_LOAD: reg_write_src_o = WB_DMEM;
               default: reg_write_src_o = WB_ALU;
            endcase
            state_d = ST_FETCH;
         end

         ST_TRAP: begin
            trap_o     = 1'b1;
            pc_write_o = 1'b1;
            pc_src_o   = PC_TRAP;
            state_d    = ST_FETCH;
         end

         default: state_d = ST_FETCH;
      endcase

      // every wait phase starts with a fresh count
      if (state_d != state_q) wd_d = '0;

      trap_cause_o = cause_q;
      state_o      = state_q;

      // outputs are forced low for the whole reset, not just after the edge
      if (rst_i) begin
         imem_req_o         = 1'b0;
         dmem_req_o         = 1'b0;
         ir_load_o          = 1'b0;
         reg_write_enable_o = 1'b0;
         mem_write_enable_o = 1'b0;
         alu_src_1_o        = 1'b0;
         alu_src_2_o        = 2'b00;
         alu_op_o           = 4'b0000;
         reg_write_src_o    = 2'b00;
         pc_write_o         = 1'b0;
         pc_src_o           = 2'b00;
         trap_o             = 1'b0;
         trap_cause_o       = 2'b00;
         state_o            = 3'd0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_FETCH;
         wd_q    <= '0;
         cause_q <= CAUSE_ILLEGAL;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         cause_q <= cause_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control

module tb_multicycle_control;

   localparam int TMO = 4;

   logic       clk;
   logic       rst_i;
   logic [6:0] opcode_i;
   logic [2:0] funct3_i;
   logic [6:0] funct7_i;
   logic       branch_taken_i;
   logic       imem_req_o, imem_ready_i;
   logic       dmem_req_o, dmem_ready_i;
   logic       ir_load_o, reg_write_enable_o, mem_write_enable_o;
   logic       alu_src_1_o;
   logic [1:0] alu_src_2_o;
   logic [3:0] alu_op_o;
   logic [1:0] reg_write_src_o;
   logic       pc_write_o;
   logic [1:0] pc_src_o;
   logic       trap_o;
   logic [1:0] trap_cause_o;
   logic [2:0] state_o;

   logic [22:0] all_out;
   assign all_out = {imem_req_o, dmem_req_o, ir_load_o, reg_write_enable_o,
                     mem_write_enable_o, alu_src_1_o, alu_src_2_o, alu_op_o,
                     reg_write_src_o, pc_write_o, pc_src_o, trap_o,
                     trap_cause_o, state_o};

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int         cycles;
      int         imem_req;
      int         dmem_req;
      int         mem_we;
      int         reg_we;
      int         pc_writes;
      int         stray;
      logic [1:0] wb_src;
      logic [1:0] pc_src;
      logic [1:0] cause;
      logic       trap;
      logic [3:0] alu_op;
      logic [1:0] src2;
      logic [7:0] states;
      bit         exec_seen;
      bit         done;
   } obs_t;

   logic [6:0] ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                            7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

   multicycle_control #(
      .TIMEOUT_CYCLES (TMO),
      .TIMEOUT_W      (8)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .opcode_i           (opcode_i),
      .funct3_i           (funct3_i),
      .funct7_i           (funct7_i),
      .branch_taken_i     (branch_taken_i),
      .imem_req_o         (imem_req_o),
      .imem_ready_i       (imem_ready_i),
      .dmem_req_o         (dmem_req_o),
      .dmem_ready_i       (dmem_ready_i),
      .ir_load_o          (ir_load_o),
      .reg_write_enable_o (reg_write_enable_o),
      .mem_write_enable_o (mem_write_enable_o),
      .alu_src_1_o        (alu_src_1_o),
      .alu_src_2_o        (alu_src_2_o),
      .alu_op_o           (alu_op_o),
      .reg_write_src_o    (reg_write_src_o),
      .pc_write_o         (pc_write_o),
      .pc_src_o           (pc_src_o),
      .trap_o             (trap_o),
      .trap_cause_o       (trap_cause_o),
      .state_o            (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RV32I legality of a non-SYSTEM encoding
   function automatic bit legal(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
      case (op)
         7'h33: return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         7'h13: begin
            if (f3 == 3'd1) return f7 == 7'h00;
            if (f3 == 3'd5) return (f7 == 7'h00) || (f7 == 7'h20);
            return 1'b1;
         end
         7'h03: return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
         7'h23: return f3 <= 3'd2;
         7'h63: return (f3 != 3'd2) && (f3 != 3'd3);
         7'h67: return f3 == 3'd0;
         7'h0F: return f3 == 3'd0;
         7'h37, 7'h17, 7'h6F: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Transaction-level expectation: totals per instruction, not per-state behaviour.
   function automatic obs_t model(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                  int iw, int dw, bit tk);
      obs_t e;
      e = '{default: 0};
      e.done      = 1'b1;
      e.pc_writes = 1;
      if (iw >= TMO) begin
         e.imem_req = TMO;
         e.cycles   = TMO + 1;
         e.trap     = 1'b1;
         e.cause    = 2'd2;
         e.pc_src   = 2'd3;
         return e;
      end
      e.imem_req = iw + 1;
      e.cycles   = iw + 2;
      if (op == 7'h73 || !legal(op, f3, f7)) begin
         e.cycles += 1;
         e.trap    = 1'b1;
         e.cause   = (op == 7'h73) ? 2'd1 : 2'd0;
         e.pc_src  = 2'd3;
         return e;
      end
      e.exec_seen = 1'b1;
      e.cycles   += 1;
      if (op == 7'h33)
         e.alu_op = {f7[5], f3};
      else if (op == 7'h13)
         e.alu_op = (f3 == 3'd1 || f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
      else
         e.alu_op = 4'd0;
      case (op)
         7'h63: e.pc_src = tk ? 2'd1 : 2'd0;
         7'h0F: e.pc_src = 2'd0;
         7'h03, 7'h23: begin
            if (dw >= TMO) begin
               e.dmem_req = TMO;
               e.mem_we   = (op == 7'h23) ? TMO : 0;
               e.cycles  += TMO + 1;
               e.trap     = 1'b1;
               e.cause    = 2'd3;
               e.pc_src   = 2'd3;
            end else begin
               e.dmem_req = dw + 1;
               e.mem_we   = (op == 7'h23) ? dw + 1 : 0;
               e.cycles  += dw + 1;
               if (op == 7'h03) begin
                  e.cycles += 1;
                  e.reg_we  = 1;
                  e.wb_src  = 2'd2;
               end
            end
         end
         default: begin
            e.cycles += 1;
            e.reg_we  = 1;
            e.wb_src  = (op == 7'h37) ? 2'd0 : (op == 7'h6F || op == 7'h67) ? 2'd3 : 2'd1;
            e.pc_src  = (op == 7'h6F) ? 2'd1 : (op == 7'h67) ? 2'd2 : 2'd0;
         end
      endcase
      return e;
   endfunction

   // Runs one instruction from its first FETCH cycle to its pc_write cycle.
   // Entered shortly after a rising edge; leaves 1 time unit after one.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input int iw, input int dw, input bit tk, output obs_t o);
      int icnt;
      int dcnt;
      o = '{default: 0};
      opcode_i       = op;
      funct3_i       = f3;
      funct7_i       = f7;
      branch_taken_i = tk;
      icnt = 0;
      dcnt = 0;
      for (int c = 0; c < 40 && !o.done; c++) begin
         imem_ready_i = imem_req_o && (icnt >= iw);
         dmem_ready_i = dmem_req_o && (dcnt >= dw);
         #1;
         o.cycles++;
         o.states = o.states | (8'd1 << state_o);
         if (imem_req_o) begin o.imem_req++; icnt++; end
         if (dmem_req_o) begin o.dmem_req++; dcnt++; end
         if (mem_write_enable_o) o.mem_we++;
         if (mem_write_enable_o && !dmem_req_o) o.stray++;
         if (state_o == 3'd2) begin
            o.exec_seen = 1'b1;
            o.alu_op    = alu_op_o;
            o.src2      = alu_src_2_o;
         end
         if (reg_write_enable_o) begin
            o.reg_we++;
            o.wb_src = reg_write_src_o;
         end
         if (pc_write_o) begin
            o.done = 1'b1;
            o.pc_writes++;
            o.pc_src = pc_src_o;
            o.trap   = trap_o;
            o.cause  = trap_cause_o;
         end
         @(posedge clk);
         #1;
      end
      imem_ready_i = 1'b0;
      dmem_ready_i = 1'b0;
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (all_out !== 23'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", all_out);
      end
      rst_i = 1'b0;
      #1;
      checks++;
      if ({imem_req_o, state_o} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_release got req=%b state=%0d exp req=1 state=0", imem_req_o, state_o);
      end
   endtask

   task automatic test_add;
      obs_t o;
      run_instr(7'h33, 3'd0, 7'h00, 0, 0, 1'b0, o);
      checks++;
      if (o.states !== 8'b0001_0111) begin
         failures++;
         $display("FAIL add_states got=%b exp=00010111", o.states);
      end
      checks++;
      if (o.alu_op !== 4'b0000 || o.src2 !== 2'b10) begin
         failures++;
         $display("FAIL add_alu got op=%b src2=%b exp op=0000 src2=10", o.alu_op, o.src2);
      end
      checks++;
      if (o.reg_we !== 1 || o.wb_src !== 2'b01) begin
         failures++;
         $display("FAIL add_wb got we=%0d src=%b exp we=1 src=01", o.reg_we, o.wb_src);
      end
      checks++;
      if (o.cycles !== 4) begin
         failures++;
         $display("FAIL add_cycles got=%0d exp=4", o.cycles);
      end
   endtask

   task automatic test_lw_wait;
      obs_t o;
      run_instr(7'h03, 3'd2, 7'h00, 0, 3, 1'b0, o);
      checks++;
      if (o.dmem_req !== 4 || o.mem_we !== 0) begin
         failures++;
         $display("FAIL lw_mem got req=%0d we=%0d exp req=4 we=0", o.dmem_req, o.mem_we);
      end
      checks++;
      if (o.wb_src !== 2'b10 || o.reg_we !== 1) begin
         failures++;
         $display("FAIL lw_wb got src=%b we=%0d exp src=10 we=1", o.wb_src, o.reg_we);
      end
      checks++;
      if (o.cycles !== 8) begin
         failures++;
         $display("FAIL lw_cycles got=%0d exp=8", o.cycles);
      end
   endtask

   task automatic test_beq;
      obs_t o;
      for (int t = 1; t >= 0; t--) begin
         run_instr(7'h63, 3'd0, 7'h00, 0, 0, t[0], o);
         checks++;
         if (o.pc_src !== {1'b0, t[0]} || o.pc_writes !== 1 || o.reg_we !== 0 || o.cycles !== 3) begin
            failures++;
            $display("FAIL beq_taken%0d got src=%b pcw=%0d rw=%0d cyc=%0d exp src=%0d pcw=1 rw=0 cyc=3",
                     t, o.pc_src, o.pc_writes, o.reg_we, o.cycles, t);
         end
      end
   endtask

   task automatic test_illegal_ecall;
      obs_t o;
      run_instr(7'h7F, 3'd0, 7'h00, 0, 0, 1'b0, o);
      checks++;
      if (o.trap !== 1'b1 || o.cause !== 2'b00 || o.states !== 8'b0010_0011 || o.cycles !== 3) begin
         failures++;
         $display("FAIL illegal_trap got trap=%b cause=%b states=%b cyc=%0d exp 1 00 00100011 3",
                  o.trap, o.cause, o.states, o.cycles);
      end
      run_instr(7'h73, 3'd0, 7'h00, 0, 0, 1'b0, o);
      checks++;
      if (o.trap !== 1'b1 || o.cause !== 2'b01 || o.pc_src !== 2'b11) begin
         failures++;
         $display("FAIL ecall_trap got trap=%b cause=%b src=%b exp 1 01 11", o.trap, o.cause, o.pc_src);
      end
      run_instr(7'h33, 3'd0, 7'h00, 0, 0, 1'b0, o);
      checks++;
      if (o.cause !== 2'b01 || o.trap !== 1'b0) begin
         failures++;
         $display("FAIL cause_hold got cause=%b trap=%b exp cause=01 trap=0", o.cause, o.trap);
      end
   endtask

   task automatic test_reset_mid_store;
      bit found;
      found          = 1'b0;
      opcode_i       = 7'h23;
      funct3_i       = 3'd2;
      funct7_i       = 7'h00;
      dmem_ready_i   = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         imem_ready_i = imem_req_o;
         #1;
         if (state_o == 3'd3) found = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      imem_ready_i = 1'b0;
      checks++;
      if (!found || dmem_req_o !== 1'b1 || mem_write_enable_o !== 1'b1) begin
         failures++;
         $display("FAIL sw_reach_mem got found=%b req=%b we=%b exp 1 1 1", found, dmem_req_o, mem_write_enable_o);
      end
      rst_i = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (all_out !== 23'd0) begin
         failures++;
         $display("FAIL sw_reset_abort got=%h exp=0", all_out);
      end
      rst_i = 1'b0;
      #1;
      checks++;
      if ({state_o, imem_req_o, dmem_req_o, mem_write_enable_o, trap_cause_o} !== 8'b000_1_0_0_00) begin
         failures++;
         $display("FAIL sw_after_reset got state=%0d ireq=%b dreq=%b we=%b cause=%b exp 0 1 0 0 00",
                  state_o, imem_req_o, dmem_req_o, mem_write_enable_o, trap_cause_o);
      end
   endtask

   task automatic test_timeouts;
      obs_t o;
      run_instr(7'h33, 3'd0, 7'h00, 99, 0, 1'b0, o);
      checks++;
      if (o.imem_req !== 4 || o.trap !== 1'b1 || o.cause !== 2'b10 || o.pc_src !== 2'b11 || o.cycles !== 5) begin
         failures++;
         $display("FAIL imem_timeout got req=%0d trap=%b cause=%b src=%b cyc=%0d exp 4 1 10 11 5",
                  o.imem_req, o.trap, o.cause, o.pc_src, o.cycles);
      end
      run_instr(7'h33, 3'd0, 7'h00, 3, 0, 1'b0, o);
      checks++;
      if (o.trap !== 1'b0 || o.reg_we !== 1 || o.cycles !== 7) begin
         failures++;
         $display("FAIL imem_ready_at_limit got trap=%b rw=%0d cyc=%0d exp 0 1 7", o.trap, o.reg_we, o.cycles);
      end
      run_instr(7'h23, 3'd2, 7'h00, 0, 99, 1'b0, o);
      checks++;
      if (o.dmem_req !== 4 || o.mem_we !== 4 || o.cause !== 2'b11 || o.trap !== 1'b1 || o.cycles !== 8) begin
         failures++;
         $display("FAIL dmem_timeout got req=%0d we=%0d cause=%b trap=%b cyc=%0d exp 4 4 11 1 8",
                  o.dmem_req, o.mem_we, o.cause, o.trap, o.cycles);
      end
   endtask

   task automatic test_random;
      obs_t       o;
      obs_t       e;
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      int         iw;
      int         dw;
      bit         tk;
      int         sel;
      for (int n = 0; n < 150; n++) begin
         sel = $urandom_range(11, 0);
         op  = (sel == 11) ? 7'($urandom) : ops[sel];
         f3  = 3'($urandom);
         case ($urandom_range(2, 0))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
         endcase
         iw = ($urandom_range(7, 0) == 0) ? $urandom_range(5, 4) : $urandom_range(3, 0);
         dw = ($urandom_range(7, 0) == 0) ? $urandom_range(5, 4) : $urandom_range(3, 0);
         tk = 1'($urandom);
         e  = model(op, f3, f7, iw, dw, tk);
         run_instr(op, f3, f7, iw, dw, tk, o);
         checks++;
         if (o.done !== e.done || o.cycles !== e.cycles) begin
            failures++;
            $display("FAIL rnd_cycles n=%0d op=%h f3=%0d f7=%h iw=%0d dw=%0d got done=%b cyc=%0d exp done=1 cyc=%0d",
                     n, op, f3, f7, iw, dw, o.done, o.cycles, e.cycles);
         end
         checks++;
         if (o.imem_req !== e.imem_req || o.dmem_req !== e.dmem_req || o.mem_we !== e.mem_we || o.stray !== 0) begin
            failures++;
            $display("FAIL rnd_mem n=%0d op=%h got ireq=%0d dreq=%0d we=%0d stray=%0d exp %0d %0d %0d 0",
                     n, op, o.imem_req, o.dmem_req, o.mem_we, o.stray, e.imem_req, e.dmem_req, e.mem_we);
         end
         checks++;
         if (o.pc_writes !== e.pc_writes || o.pc_src !== e.pc_src || o.trap !== e.trap || o.reg_we !== e.reg_we) begin
            failures++;
            $display("FAIL rnd_ctrl n=%0d op=%h f3=%0d got pcw=%0d src=%b trap=%b rw=%0d exp %0d %b %b %0d",
                     n, op, f3, o.pc_writes, o.pc_src, o.trap, o.reg_we, e.pc_writes, e.pc_src, e.trap, e.reg_we);
         end
         if (e.reg_we == 1) begin
            checks++;
            if (o.wb_src !== e.wb_src) begin
               failures++;
               $display("FAIL rnd_wb_src n=%0d op=%h got=%b exp=%b", n, op, o.wb_src, e.wb_src);
            end
         end
         if (e.trap) begin
            checks++;
            if (o.cause !== e.cause) begin
               failures++;
               $display("FAIL rnd_cause n=%0d op=%h got=%b exp=%b", n, op, o.cause, e.cause);
            end
         end
         checks++;
         if (o.exec_seen !== e.exec_seen || (e.exec_seen && o.alu_op !== e.alu_op)) begin
            failures++;
            $display("FAIL rnd_alu n=%0d op=%h f3=%0d f7=%h got exec=%b op=%b exp exec=%b op=%b",
                     n, op, f3, f7, o.exec_seen, o.alu_op, e.exec_seen, e.alu_op);
         end
      end
   endtask

   initial begin
      rst_i          = 1'b1;
      opcode_i       = 7'h00;
      funct3_i       = 3'd0;
      funct7_i       = 7'h00;
      branch_taken_i = 1'b0;
      imem_ready_i   = 1'b0;
      dmem_ready_i   = 1'b0;
      test_reset;
      test_add;
      test_lw_wait;
      test_beq;
      test_illegal_ecall;
      test_reset_mid_store;
      test_timeouts;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 0, giving the memory-handshake watchdog limit in cycles; 0 disables the watchdog.
REQ-002 SHALL have parameter TIMEOUT_W, default 8, giving the watchdog counter width; TIMEOUT_CYCLES SHALL be < 2**TIMEOUT_W.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports opcode_i (input, 7), funct3_i (input, 3) and funct7_i (input, 7): fields of the latched instruction register.
REQ-006 SHALL have port branch_taken_i, input, 1 bit: the external comparator result for the current branch.
REQ-007 SHALL have ports imem_req_o (output, 1) and imem_ready_i (input, 1): the instruction-fetch handshake.
REQ-008 SHALL have ports dmem_req_o (output, 1) and dmem_ready_i (input, 1): the data-access handshake.
REQ-009 SHALL have port ir_load_o, output, 1 bit: a one-cycle strobe that loads the instruction register.
REQ-010 SHALL have ports reg_write_enable_o (output, 1) and mem_write_enable_o (output, 1).
REQ-011 SHALL have ports alu_src_1_o (output, 1; 0=rs1, 1=pc) and alu_src_2_o (output, 2; 00=imm_i, 01=imm_s, 10=rs2, 11=imm_u).
REQ-012 SHALL have port alu_op_o, output, 4 bits: {funct7_i[5], funct3_i} for OP and for OP-IMM shifts, {0, funct3_i} for other OP-IMM, and 0000 (ADD) otherwise.
REQ-013 SHALL have port reg_write_src_o, output, 2 bits: 00=imm_u, 01=alu, 10=dmem, 11=pc+4.
REQ-014 SHALL have ports pc_write_o (output, 1) and pc_src_o (output, 2; 00=pc+4, 01=pc+imm_b/j, 10=alu result (JALR), 11=trap vector).
REQ-015 SHALL have ports trap_o (output, 1), trap_cause_o (output, 2; 00=illegal, 01=ecall/ebreak, 10=imem timeout, 11=dmem timeout) and state_o (output, 3).

Function
REQ-016 SHALL implement an FSM with states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6 and 7 SHALL return to FETCH on the next edge.
REQ-017 FETCH: SHALL hold imem_req_o=1 until imem_ready_i=1; in the ready cycle it SHALL pulse ir_load_o and go to DECODE.
REQ-018 DECODE: SHALL go to TRAP with cause 00 for an unsupported opcode or an invalid funct3/funct7 combination, and with cause 01 for SYSTEM; otherwise it SHALL go to EXEC.
REQ-019 EXEC: LOAD and STORE SHALL go to MEM.
REQ-020 EXEC: BRANCH SHALL assert pc_write_o with pc_src_o=01 if branch_taken_i=1, else 00, and go to FETCH.
REQ-021 EXEC: FENCE SHALL assert pc_write_o with pc_src_o=00 and go to FETCH.
REQ-022 EXEC: all other classes SHALL go to WB.
REQ-023 MEM: SHALL hold dmem_req_o=1 until dmem_ready_i=1; STORE SHALL also hold mem_write_enable_o=1 for the same cycles.
REQ-024 MEM, ready cycle: STORE SHALL assert pc_write_o with pc_src_o=00 and go to FETCH; LOAD SHALL go to WB.
REQ-025 WB: SHALL assert reg_write_enable_o and pc_write_o for exactly one cycle, then go to FETCH.
REQ-026 WB pc_src_o SHALL be 01 for JAL, 10 for JALR and 00 otherwise.
REQ-027 WB reg_write_src_o SHALL be 00 for LUI, 11 for JAL/JALR, 10 for LOAD and 01 otherwise.
REQ-028 TRAP: SHALL assert trap_o and pc_write_o with pc_src_o=11 for exactly one cycle, then go to FETCH; trap_cause_o SHALL hold its value until the next trap.
REQ-029 Watchdog: a counter SHALL clear on entry to FETCH or MEM and increment each cycle the request waits; when it reaches TIMEOUT_CYCLES with ready still 0 (TIMEOUT_CYCLES>0), the FSM SHALL drop the request and go to TRAP with cause 10 or 11.
REQ-030 If ready arrives in the same cycle the limit is reached, ready SHALL win and no trap SHALL occur.
REQ-031 Control outputs SHALL be combinational from state and the instruction fields; every output not named for the current state SHALL be 0.
REQ-032 Latency with zero-wait memories SHALL be: ALU/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH and FENCE 3, trap 3.
REQ-033 Writes to rd=x0 SHALL NOT be suppressed by this block; the register file ignores them.

Reset
REQ-034 While rst_i=1, state SHALL be FETCH, the watchdog and trap_cause_o SHALL be 0, and every output SHALL be 0 (imem_req_o included).
REQ-035 imem_req_o SHALL assert in the first cycle after rst_i falls.
REQ-036 Reset asserted mid-instruction SHALL abort the instruction at the next edge: no pending req, write or pc_write may remain asserted.

Structure
REQ-037 Package control_pkg SHALL hold the state encoding, RV32I opcode constants, ALU op codes, and the alu_src, reg_write_src, pc_src and trap-cause encodings.
REQ-038 Sub-module main_decoder SHALL map opcode/funct3/funct7 combinationally to instruction class and illegal flag.
REQ-039 All sequential logic SHALL reside in multicycle_control.

Verification
REQ-040 ADD x1,x2,x3 (0x003100B3), zero-wait memories: states 0,1,2,4 seen; alu_op_o=0000 in EXEC; a single reg_write_enable_o with reg_write_src_o=01.
REQ-041 LW with dmem_ready_i delayed 3 cycles: dmem_req_o high 4 cycles, mem_write_enable_o=0 throughout, WB reg_write_src_o=10, total 8 cycles.
REQ-042 BEQ with branch_taken_i=1, then 0: pc_src_o=01, then 00, each with one pc_write_o in EXEC and no reg write.
REQ-043 TIMEOUT_CYCLES=4 and imem_ready_i held 0: imem_req_o drops after 4 cycles; trap_o=1 with trap_cause_o=10 and pc_src_o=11.
REQ-044 opcode 0x7F: TRAP entered from DECODE with trap_cause_o=00; ECALL (0x00000073) gives cause 01.
REQ-045 rst_i pulsed during MEM of an SW: dmem_req_o and mem_write_enable_o are 0 on the next edge and state_o=0.
